// File: rtl/sha2_pkg.sv
// Shared constants and encodings for the SHA-256 message padder and its block merge logic.
package sha2_pkg;

  localparam int BLOCK_BYTES   = 64;
  localparam int BLOCK_W       = 512;
  localparam int LEN_FIELD_OFS = 56;
  localparam logic [7:0] PAD_BYTE = 8'h80;

  typedef enum logic [2:0] {
    ST_FILL,
    ST_SEND_DATA,
    ST_PAD,
    ST_SEND_PAD,
    ST_LENBLK,
    ST_SEND_LAST
  } state_t;

  typedef enum logic {
    MERGE_PAD,
    MERGE_LEN
  } merge_mode_t;

endpackage

// File: rtl/sha2_pad_merge.sv
// Combinational block builder: keeps data bytes below pos, inserts the 0x80 marker and the
// 64-bit big-endian bit length, or produces a length-only block.
module sha2_pad_merge
  import sha2_pkg::*;
(
  input  logic [BLOCK_W-1:0] i_buf,
  input  logic [5:0]         i_pos,
  input  logic [63:0]        i_len_bits,
  input  merge_mode_t        i_mode,
  output logic [BLOCK_W-1:0] o_block
);

  always_comb begin
    o_block = '0;
    if (i_mode == MERGE_PAD) begin
      for (int b = 0; b < BLOCK_BYTES; b++) begin
        if (b < int'(i_pos)) begin
          o_block[BLOCK_W-1-8*b -: 8] = i_buf[BLOCK_W-1-8*b -: 8];
        end else if (b == int'(i_pos)) begin
          o_block[BLOCK_W-1-8*b -: 8] = PAD_BYTE;
        end
      end
    end
    // Length fits only when the marker landed before the length field.
    if (i_mode == MERGE_LEN || i_pos < 6'(LEN_FIELD_OFS)) begin
      o_block[63:0] = i_len_bits;
    end
  end

endmodule

// File: rtl/sha2_msg_padder.sv
// SHA-256 message padder: collects a byte stream into a 512-bit buffer that doubles as the
// output register, and emits padded blocks over a valid/ready handshake.
module sha2_msg_padder
  import sha2_pkg::*;
#(
  parameter int LEN_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [7:0]         in_data,
  input  logic               in_last,
  input  logic               in_empty,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BLOCK_W-1:0] out_block,
  output logic               out_first,
  output logic               out_last,
  output logic               len_ovf
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [5:0]         r_pos;
  logic [LEN_W-1:0]   r_total;
  logic [BLOCK_W-1:0] r_buf;
  logic               r_valid;
  logic               r_first;
  logic               r_last;
  logic               r_ovf;
  logic               r_data_last;
  logic               r_first_pend;
  logic               r_msg_new;

  logic               w_accept;
  logic               w_byte_wr;
  logic [LEN_W-1:0]   w_total_inc;
  logic [63:0]        w_len_bits;
  logic [8:0]         w_wr_hi;
  merge_mode_t        w_mode;
  logic [BLOCK_W-1:0] w_merged;

  assign in_ready    = (r_state == ST_FILL) && !rst;
  assign w_accept    = in_valid && in_ready;
  assign w_byte_wr   = w_accept && !(in_last && in_empty);
  assign w_total_inc = r_total + 1'b1;
  assign w_len_bits  = 64'(r_total) << 3;
  assign w_wr_hi     = 9'(BLOCK_W - 1) - {r_pos, 3'b000};
  assign w_mode      = (r_state == ST_LENBLK) ? MERGE_LEN : MERGE_PAD;

  assign out_valid = r_valid;
  assign out_block = r_buf;
  assign out_first = r_first;
  assign out_last  = r_last;
  assign len_ovf   = r_ovf;

  sha2_pad_merge u_merge (
    .i_buf      (r_buf),
    .i_pos      (r_pos),
    .i_len_bits (w_len_bits),
    .i_mode     (w_mode),
    .o_block    (w_merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_FILL;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_accept) begin
          if (w_byte_wr && r_pos == 6'd63) w_state_nxt = ST_SEND_DATA;
          else if (in_last)                 w_state_nxt = ST_PAD;
        end
      end
      ST_SEND_DATA: if (out_ready) w_state_nxt = r_data_last ? ST_PAD : ST_FILL;
      ST_PAD:       w_state_nxt = (r_pos < 6'(LEN_FIELD_OFS)) ? ST_SEND_LAST : ST_SEND_PAD;
      ST_SEND_PAD:  if (out_ready) w_state_nxt = ST_LENBLK;
      ST_LENBLK:    w_state_nxt = ST_SEND_LAST;
      ST_SEND_LAST: if (out_ready) w_state_nxt = ST_FILL;
      default:      w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pos        <= '0;
      r_total      <= '0;
      r_buf        <= '0;
      r_valid      <= 1'b0;
      r_first      <= 1'b0;
      r_last       <= 1'b0;
      r_ovf        <= 1'b0;
      r_data_last  <= 1'b0;
      r_first_pend <= 1'b1;
      r_msg_new    <= 1'b1;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_msg_new <= 1'b0;
            if (r_msg_new) r_ovf <= 1'b0;
            if (w_byte_wr) begin
              r_buf[w_wr_hi -: 8] <= in_data;
              r_pos               <= r_pos + 1'b1;
              r_total             <= w_total_inc;
              if (w_total_inc == '0) r_ovf <= 1'b1;
              // 64th byte: the buffer itself becomes the outgoing data block.
              if (r_pos == 6'd63) begin
                r_valid     <= 1'b1;
                r_first     <= r_first_pend;
                r_last      <= 1'b0;
                r_data_last <= in_last;
              end
            end
          end
        end
        ST_SEND_DATA, ST_SEND_PAD: begin
          if (out_ready) begin
            r_valid      <= 1'b0;
            r_first_pend <= 1'b0;
          end
        end
        ST_PAD: begin
          r_buf   <= w_merged;
          r_valid <= 1'b1;
          r_first <= r_first_pend;
          r_last  <= (r_pos < 6'(LEN_FIELD_OFS));
        end
        ST_LENBLK: begin
          r_buf   <= w_merged;
          r_valid <= 1'b1;
          r_first <= 1'b0;
          r_last  <= 1'b1;
        end
        ST_SEND_LAST: begin
          if (out_ready) begin
            r_valid      <= 1'b0;
            r_pos        <= '0;
            r_total      <= '0;
            r_first_pend <= 1'b1;
            r_msg_new    <= 1'b1;
          end
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_sha2_msg_padder.sv
// Bench for sha2_msg_padder: directed and random messages compared against a byte-level
// padding model, plus reset, latency and back-pressure stability checks.
module tb_sha2_msg_padder;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         in_empty;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] out_block;
  logic         out_first;
  logic         out_last;
  logic         len_ovf;

  typedef struct packed {
    logic [511:0] blk;
    logic         first;
    logic         last;
  } blk_t;

  blk_t       got_q[$];
  blk_t       exp_q[$];
  logic [7:0] tx_q[$];
  int         got_base;
  int         rdy_mode;
  int         n_total = 0;
  int         n_pass  = 0;

  always #5 clk = ~clk;

  sha2_msg_padder #(.LEN_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_empty  (in_empty),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_block (out_block),
    .out_first (out_first),
    .out_last  (out_last),
    .len_ovf   (len_ovf)
  );

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back('{out_block, out_first, out_last});
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        default: out_ready = ($urandom_range(0, 2) != 0);
      endcase
    end
  end

  task automatic chk_blk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_v(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Padding rule: message, 0x80, zeros to 56 mod 64, then the 64-bit big-endian bit count.
  task automatic build_expected(input bit empty);
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] blk;
    int           nb;
    p.delete();
    if (!empty) p = tx_q;
    bits = 64'(p.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int k = 7; k >= 0; k--) p.push_back(bits[8*k +: 8]);
    nb = p.size() / 64;
    exp_q.delete();
    for (int b = 0; b < nb; b++) begin
      blk = '0;
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = p[64*b+j];
      exp_q.push_back('{blk, (b == 0), (b == nb - 1)});
    end
  endtask

  task automatic send_msg(input bit empty, input bit gaps, input bit no_last);
    int i = 0;
    int tries = 0;
    int n = empty ? 1 : tx_q.size();
    while (i < n && tries < 5000) begin
      @(posedge clk);
      #1;
      tries++;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        continue;
      end
      in_valid = 1'b1;
      in_data  = empty ? 8'($urandom) : tx_q[i];
      in_last  = (i == n - 1) && !no_last;
      in_empty = empty;
      @(negedge clk);
      if (in_ready) i++;
    end
    if (i < n) chk_v("send_timeout", 64'(i), 64'(n));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_empty = 1'b0;
  endtask

  task automatic collect_and_compare(input string tag);
    int t = 0;
    while (got_q.size() - got_base < exp_q.size() && t < 3000) begin
      @(negedge clk);
      t++;
    end
    repeat (4) @(negedge clk);
    chk_v({tag, "_nblk"}, 64'(got_q.size() - got_base), 64'(exp_q.size()));
    for (int b = 0; b < exp_q.size() && got_base + b < got_q.size(); b++) begin
      chk_blk({tag, "_blk"}, got_q[got_base+b].blk, exp_q[b].blk);
      chk_v({tag, "_first"}, 64'(got_q[got_base+b].first), 64'(exp_q[b].first));
      chk_v({tag, "_last"}, 64'(got_q[got_base+b].last), 64'(exp_q[b].last));
    end
    got_base = got_q.size();
  endtask

  task automatic run_msg(input string tag, input bit empty, input bit gaps);
    build_expected(empty);
    send_msg(empty, gaps, 1'b0);
    collect_and_compare(tag);
  endtask

  task automatic load_str(input string s);
    tx_q.delete();
    for (int k = 0; k < s.len(); k++) tx_q.push_back(s[k]);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; in_empty = 1'b0;
    rdy_mode = 1; got_base = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_v("rst_in_ready", 64'(in_ready), 64'd0);
    chk_v("rst_out_valid", 64'(out_valid), 64'd0);
    chk_blk("rst_out_block", out_block, 512'd0);
    chk_v("rst_flags", {62'd0, out_first, out_last}, 64'd0);
    chk_v("rst_len_ovf", 64'(len_ovf), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_v("idle_in_ready", 64'(in_ready), 64'd1);

    // "abc" with latency check and a literal reference block
    load_str("abc");
    build_expected(1'b0);
    chk_blk("abc_model", exp_q[0].blk, {32'h61626380, 416'd0, 64'h18});
    send_msg(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_v("abc_lat_pad", 64'(out_valid), 64'd0);
    @(negedge clk);
    chk_v("abc_lat_valid", 64'(out_valid), 64'd1);
    collect_and_compare("abc");

    load_str("denis");
    run_msg("denis", 1'b0, 1'b0);
    tx_q.delete();
    run_msg("empty", 1'b1, 1'b0);

    tx_q.delete();
    repeat (55) tx_q.push_back(8'h41);
    run_msg("len55", 1'b0, 1'b0);
    tx_q.push_back(8'h41);
    run_msg("len56", 1'b0, 1'b0);
    tx_q.delete();
    for (int k = 0; k < 64; k++) tx_q.push_back(8'(k));
    run_msg("len64", 1'b0, 1'b0);

    // Back-pressure held for 5 cycles on the final block
    rdy_mode = 0;
    load_str("abc");
    build_expected(1'b0);
    send_msg(1'b0, 1'b0, 1'b0);
    begin
      int t = 0;
      while (!out_valid && t < 50) begin
        @(negedge clk);
        t++;
      end
    end
    for (int k = 0; k < 5; k++) begin
      chk_blk("hold_block", out_block, exp_q[0].blk);
      chk_v("hold_valid_ready", {62'd0, out_valid, in_ready}, 64'b10);
      chk_v("hold_flags", {62'd0, out_first, out_last}, 64'b11);
      @(negedge clk);
    end
    rdy_mode = 1;
    collect_and_compare("hold");

    // Reset in the middle of a 20-byte message discards it
    tx_q.delete();
    repeat (20) tx_q.push_back(8'($urandom));
    send_msg(1'b0, 1'b0, 1'b1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk_v("midrst_out_valid", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    got_base = got_q.size();
    load_str("abc");
    run_msg("post_rst_abc", 1'b0, 1'b0);
    chk_v("post_rst_len_ovf", 64'(len_ovf), 64'd0);

    // Random lengths with input gaps and random back-pressure
    rdy_mode = 2;
    for (int m = 0; m < 8; m++) begin
      int len;
      len = $urandom_range(0, 140);
      tx_q.delete();
      for (int k = 0; k < len; k++) tx_q.push_back(8'($urandom));
      run_msg("rand", (len == 0), 1'b1);
    end
    chk_v("final_len_ovf", 64'(len_ovf), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
